// File: rtl/pto_move_scheduler_if.sv
// Command channel of the three-axis pulse-train move scheduler.
// master drives the command and abort lines; slave returns cmd_ready.
interface pto_move_scheduler_if #(
    parameter int STEP_W = 24,
    parameter int PER_W  = 16
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [3*STEP_W-1:0]   cmd_steps;
    logic [3*PER_W-1:0]    cmd_period;
    logic [2:0]            cmd_dir;
    logic                  abort;

    modport master (
        output cmd_valid, cmd_steps, cmd_period, cmd_dir, abort,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_steps, cmd_period, cmd_dir, abort,
        output cmd_ready
    );
endinterface

// File: rtl/pto_move_scheduler.sv
// Three-axis step/direction pulse-train scheduler: latches a move, waits the
// direction setup time, then emits N pulses of P-high/P-low per axis.
module pto_move_scheduler #(
    parameter int STEP_W        = 24,
    parameter int PER_W         = 16,
    parameter int DIR_SETUP_CYC = 100
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    pto_move_scheduler_if.slave cmd,
    output logic [2:0]          pto,
    output logic [2:0]          motor_dir,
    output logic                busy,
    output logic                done,
    output logic                aborted
);
    localparam int SET_W = (DIR_SETUP_CYC > 1) ? $clog2(DIR_SETUP_CYC) : 1;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_DIR_SETUP = 2'd1;
    localparam logic [1:0] S_RUN       = 2'd2;
    localparam logic [1:0] S_DONE      = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [SET_W-1:0] setup_cnt_q, setup_cnt_d;
    logic [2:0]       motor_dir_q, motor_dir_d;
    logic             aborted_q, aborted_d;

    logic             accept;
    logic             kill;
    logic             run_start;
    logic             in_run;
    logic [2:0]       axis_pto;
    logic [2:0]       axis_active_d;

    // Reset is folded in so the channel reads not-ready during reset.
    assign cmd.cmd_ready = (state_q == S_IDLE) && !cmd.abort && !reset_reset;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign busy          = (state_q == S_DIR_SETUP) || (state_q == S_RUN);
    assign kill          = busy && cmd.abort;
    assign run_start     = (state_q == S_DIR_SETUP) && (setup_cnt_q == '0) && !cmd.abort;
    assign in_run        = (state_q == S_RUN);

    for (genvar gi = 0; gi < 3; gi++) begin : g_axis
        logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
        logic [PER_W-1:0]  half_cnt_q, half_cnt_d;
        logic [PER_W-1:0]  period_q, period_d;
        logic [PER_W-1:0]  half_reload;
        logic              pto_q, pto_d;
        logic              active_q, active_d;

        // A zero half-period behaves as one cycle, so reload 0 in both cases.
        assign half_reload = (period_q == '0) ? '0 : period_q - PER_W'(1);

        // step_cnt holds the steps still owed, including the one in flight.
        always_comb begin
            step_cnt_d = step_cnt_q;
            half_cnt_d = half_cnt_q;
            period_d   = period_q;
            pto_d      = pto_q;
            active_d   = active_q;
            if (accept) begin
                step_cnt_d = cmd.cmd_steps[gi*STEP_W +: STEP_W];
                period_d   = cmd.cmd_period[gi*PER_W +: PER_W];
                pto_d      = 1'b0;
                active_d   = 1'b0;
            end else if (kill) begin
                pto_d    = 1'b0;
                active_d = 1'b0;
            end else if (run_start) begin
                active_d   = (step_cnt_q != '0);
                pto_d      = (step_cnt_q != '0);
                half_cnt_d = half_reload;
            end else if (in_run && active_q) begin
                if (half_cnt_q == '0) begin
                    half_cnt_d = half_reload;
                    if (pto_q) begin
                        pto_d = 1'b0;
                    end else if (step_cnt_q == STEP_W'(1)) begin
                        step_cnt_d = '0;
                        active_d   = 1'b0;
                    end else begin
                        step_cnt_d = step_cnt_q - STEP_W'(1);
                        pto_d      = 1'b1;
                    end
                end else begin
                    half_cnt_d = half_cnt_q - PER_W'(1);
                end
            end
        end

        always_ff @(posedge clk_clk or posedge reset_reset) begin
            if (reset_reset) begin
                step_cnt_q <= '0;
                half_cnt_q <= '0;
                period_q   <= '0;
                pto_q      <= 1'b0;
                active_q   <= 1'b0;
            end else begin
                step_cnt_q <= step_cnt_d;
                half_cnt_q <= half_cnt_d;
                period_q   <= period_d;
                pto_q      <= pto_d;
                active_q   <= active_d;
            end
        end

        assign axis_pto[gi]      = pto_q;
        assign axis_active_d[gi] = active_d;
    end

    always_comb begin
        state_d     = state_q;
        setup_cnt_d = setup_cnt_q;
        motor_dir_d = motor_dir_q;
        aborted_d   = aborted_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    aborted_d = 1'b0;
                    if (cmd.cmd_steps == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d     = S_DIR_SETUP;
                        motor_dir_d = cmd.cmd_dir;
                        setup_cnt_d = SET_W'(DIR_SETUP_CYC - 1);
                    end
                end
            end
            S_DIR_SETUP: begin
                if (cmd.abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (setup_cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    setup_cnt_d = setup_cnt_q - SET_W'(1);
                end
            end
            S_RUN: begin
                if (cmd.abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (axis_active_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q     <= S_IDLE;
            setup_cnt_q <= '0;
            motor_dir_q <= '0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            setup_cnt_q <= setup_cnt_d;
            motor_dir_q <= motor_dir_d;
            aborted_q   <= aborted_d;
        end
    end

    assign pto       = axis_pto;
    assign motor_dir = motor_dir_q;
    assign done      = (state_q == S_DONE);
    assign aborted   = aborted_q;
endmodule
